// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - Parametrised modulo up/down counter with load, wrap/saturate and event flags
module mod_counter #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX     = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] cmp,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             unf,
    output logic             match
);

    localparam logic [WIDTH:0]   MAX_X = {1'b0, MAX};
    localparam logic [WIDTH:0]   ONE_X = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH:0]   inc_x;
    logic             past_max;
    logic             at_max;
    logic             above_max;
    logic             at_zero;

    always_comb begin
        // One extra bit keeps q+1 from aliasing to 0 when MAX is all ones.
        inc_x     = {1'b0, q_q} + ONE_X;
        past_max  = inc_x > MAX_X;
        at_max    = q_q == MAX;
        above_max = q_q > MAX;
        at_zero   = q_q == '0;
    end

    always_comb begin
        q_d   = q_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (load) begin
            q_d = (d > MAX) ? MAX : d;
        end else if (en) begin
            if (up) begin
                if (past_max) begin
                    ovf_d = 1'b1;
                    q_d   = (sat && at_max) ? MAX : '0;
                end else begin
                    q_d = inc_x[WIDTH-1:0];
                end
            end else begin
                if (at_zero) begin
                    unf_d = 1'b1;
                    q_d   = sat ? '0 : MAX;
                end else if (above_max) begin
                    q_d = MAX;
                end else begin
                    q_d = q_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= RST_VAL;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign q     = q_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
    assign tc    = en & ((up & at_max) | (~up & at_zero));
    assign match = q_q == cmp;

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - Self-checking bench for mod_counter against a behavioural model
module tb_mod_counter;

    localparam int M = 5;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, up, sat, load;
    logic [2:0] d, cmp, q;
    logic       tc, ovf, unf, match;

    logic       w_rst, w_en, w_up, w_sat, w_load;
    logic [7:0] w_d, w_cmp, w_q;
    logic       w_tc, w_ovf, w_unf, w_match;

    mod_counter #(.WIDTH(3), .MAX(3'd5), .RST_VAL(3'd0)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
        .d(d), .cmp(cmp), .q(q), .tc(tc), .ovf(ovf), .unf(unf), .match(match)
    );

    mod_counter wide (
        .clk(clk), .rst(w_rst), .en(w_en), .up(w_up), .sat(w_sat), .load(w_load),
        .d(w_d), .cmp(w_cmp), .q(w_q), .tc(w_tc), .ovf(w_ovf), .unf(w_unf), .match(w_match)
    );

    int total = 0;
    int bad   = 0;
    int m_q   = 0;
    bit m_ovf = 0;
    bit m_unf = 0;

    // Model: modulo-(M+1) counting on plain integers, applied at each rising edge.
    task automatic tick();
        int nq;
        bit no, nu;
        nq = m_q; no = 0; nu = 0;
        if (rst) nq = 0;
        else if (load) nq = (int'(d) > M) ? M : int'(d);
        else if (en && up) begin
            if (m_q + 1 > M) begin no = 1; nq = sat ? M : 0; end
            else nq = m_q + 1;
        end else if (en) begin
            if (m_q - 1 < 0) begin nu = 1; nq = sat ? 0 : M; end
            else nq = m_q - 1;
        end
        @(posedge clk);
        #1;
        m_q = nq; m_ovf = no; m_unf = nu;
    endtask

    task automatic idle_inputs();
        rst = 0; en = 0; up = 1; sat = 0; load = 0; d = 0; cmp = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        total++; if (q !== 3'd0) begin bad++; $display("FAIL reset_q got %0d want 0", q); end
        total++; if (ovf !== 1'b0 || unf !== 1'b0) begin bad++; $display("FAIL reset_flags got ovf=%0b unf=%0b want 0 0", ovf, unf); end
        rst = 0;
    endtask

    task automatic test_wrap_up();
        int exp_q[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
        int prev;
        en = 1; up = 1; sat = 0;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            total++; if (tc !== (prev == 5)) begin bad++; $display("FAIL wrap_tc step %0d got %0b want %0b", i, tc, prev == 5); end
            tick();
            total++; if (q !== 3'(exp_q[i])) begin bad++; $display("FAIL wrap_q step %0d got %0d want %0d", i, q, exp_q[i]); end
            total++; if (ovf !== (prev == 5)) begin bad++; $display("FAIL wrap_ovf step %0d got %0b want %0b", i, ovf, prev == 5); end
            prev = exp_q[i];
        end
        en = 0;
    endtask

    task automatic test_saturate();
        bit exp_ovf[4] = '{0, 1, 1, 1};
        load = 1; d = 3'd4; tick(); load = 0;
        en = 1; up = 1; sat = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (q !== 3'd5 || ovf !== exp_ovf[i]) begin bad++; $display("FAIL sat_up step %0d got q=%0d ovf=%0b want q=5 ovf=%0b", i, q, ovf, exp_ovf[i]); end
        end
        up = 0;
        tick();
        total++; if (q !== 3'd4 || ovf !== 1'b0 || unf !== 1'b0) begin bad++; $display("FAIL sat_turn got q=%0d ovf=%0b unf=%0b want 4 0 0", q, ovf, unf); end
        en = 0; sat = 0;
    endtask

    task automatic test_down();
        int exp_q[3] = '{0, 5, 4};
        bit exp_u[3] = '{0, 1, 0};
        load = 1; d = 3'd1; tick(); load = 0;
        en = 1; up = 0; sat = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (tc !== (i == 1)) begin bad++; $display("FAIL down_tc step %0d got %0b want %0b", i, tc, i == 1); end
            tick();
            total++; if (q !== 3'(exp_q[i]) || unf !== exp_u[i] || ovf !== 1'b0) begin bad++; $display("FAIL down step %0d got q=%0d unf=%0b ovf=%0b want q=%0d unf=%0b ovf=0", i, q, unf, ovf, exp_q[i], exp_u[i]); end
        end
        load = 1; d = 3'd0; tick(); load = 0;
        sat = 1;
        tick();
        total++; if (q !== 3'd0 || unf !== 1'b1) begin bad++; $display("FAIL down_sat got q=%0d unf=%0b want 0 1", q, unf); end
        en = 0; sat = 0; up = 1;
    endtask

    task automatic test_load();
        en = 1; up = 1; load = 1; d = 3'd3;
        tick();
        total++; if (q !== 3'd3) begin bad++; $display("FAIL load_over_en got %0d want 3", q); end
        d = 3'd7;
        tick();
        total++; if (q !== 3'd5 || ovf !== 1'b0) begin bad++; $display("FAIL load_clamp got q=%0d ovf=%0b want 5 0", q, ovf); end
        rst = 1; d = 3'd3;
        tick();
        total++; if (q !== 3'd0) begin bad++; $display("FAIL rst_over_load got %0d want 0", q); end
        rst = 0; load = 0; en = 0;
    endtask

    task automatic test_mid_reset();
        en = 1; up = 1; sat = 0;
        for (int i = 0; i < 4; i++) tick();
        total++; if (q !== 3'd4) begin bad++; $display("FAIL mid_pre got %0d want 4", q); end
        rst = 1;
        tick();
        total++; if (q !== 3'd0 || ovf !== 1'b0 || unf !== 1'b0) begin bad++; $display("FAIL mid_rst got q=%0d ovf=%0b unf=%0b want 0 0 0", q, ovf, unf); end
        rst = 0;
        tick();
        tick();
        total++; if (q !== 3'd2) begin bad++; $display("FAIL mid_resume got %0d want 2", q); end
        en = 0;
    endtask

    task automatic test_match();
        cmp = 3'd3;
        load = 1; d = 3'd0; tick(); load = 0;
        en = 1;
        for (int i = 0; i < 10; i++) begin
            up = (i < 5);
            #1;
            total++; if (match !== (m_q == 3)) begin bad++; $display("FAIL match step %0d q=%0d got %0b want %0b", i, q, match, m_q == 3); end
            tick();
        end
        load = 1; d = 3'd3; tick(); load = 0;
        en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (q !== 3'd3 || match !== 1'b1 || ovf !== 1'b0 || unf !== 1'b0) begin bad++; $display("FAIL match_hold got q=%0d match=%0b ovf=%0b unf=%0b want 3 1 0 0", q, match, ovf, unf); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 49) == 0);
            load = ($urandom_range(0, 9) == 0);
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1);
            sat  = ($urandom_range(0, 3) == 0);
            d    = 3'($urandom_range(0, 7));
            cmp  = 3'($urandom_range(0, 7));
            #1;
            total++; if (tc !== (en && ((up && m_q == M) || (!up && m_q == 0)))) begin bad++; $display("FAIL rnd_tc cycle %0d got %0b q=%0d", i, tc, m_q); end
            total++; if (match !== (m_q == int'(cmp))) begin bad++; $display("FAIL rnd_match cycle %0d got %0b want %0b", i, match, m_q == int'(cmp)); end
            tick();
            total++; if (q !== 3'(m_q) || ovf !== m_ovf || unf !== m_unf) begin bad++; $display("FAIL rnd_state cycle %0d got q=%0d ovf=%0b unf=%0b want q=%0d ovf=%0b unf=%0b", i, q, ovf, unf, m_q, m_ovf, m_unf); end
            total++; if (ovf && unf) begin bad++; $display("FAIL rnd_both cycle %0d got ovf=1 unf=1 want not both", i); end
        end
        idle_inputs();
    endtask

    task automatic test_wide();
        w_rst = 1; tick(); w_rst = 0;
        total++; if (w_q !== 8'd0) begin bad++; $display("FAIL wide_reset got %0d want 0", w_q); end
        w_load = 1; w_d = 8'd255; tick(); w_load = 0;
        w_en = 1; w_up = 1; w_sat = 0;
        #1;
        total++; if (w_tc !== 1'b1) begin bad++; $display("FAIL wide_tc got %0b want 1", w_tc); end
        tick();
        total++; if (w_q !== 8'd0 || w_ovf !== 1'b1) begin bad++; $display("FAIL wide_wrap got q=%0d ovf=%0b want 0 1", w_q, w_ovf); end
        w_load = 1; tick(); w_load = 0;
        w_sat = 1;
        tick();
        total++; if (w_q !== 8'd255 || w_ovf !== 1'b1) begin bad++; $display("FAIL wide_sat got q=%0d ovf=%0b want 255 1", w_q, w_ovf); end
        w_en = 0;
    endtask

    initial begin
        idle_inputs();
        w_rst = 1; w_en = 0; w_up = 1; w_sat = 0; w_load = 0; w_d = 0; w_cmp = 0;
        #1;
        test_reset();
        test_wrap_up();
        test_saturate();
        test_down();
        test_load();
        test_mid_reset();
        test_match();
        test_random();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
